// File: rtl/comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// three-way compare result.
package comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        EQ = 2'b00,
        GT = 2'b01,
        LT = 2'b10
    } cmp_result_t;

    function automatic cmp_result_t to_result(input logic gt, input logic lt);
        return gt ? GT : (lt ? LT : EQ);
    endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational CHUNK-bit unsigned slice comparator; the generalised form of
// the old 2-bit comparator.
module comp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o,
    output logic             eq_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comp_nbit_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle MSB-first.
// Define COMP_CONST_LATENCY_EN to always step every slice (data-independent latency).
module comp_nbit_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             G2,
    output logic             L2,
    output logic             E2
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic [WIDTH-1:0] p_q, q_q;
    logic [IDX_W-1:0] idx_q;
    cmp_result_t      res_q, res_d, slice_res;
    logic             last_d;
    logic             done_q, g_q, l_q, e_q;
    logic             slice_gt, slice_lt, slice_eq;

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i  (p_q[WIDTH-1 -: CHUNK]),
        .b_i  (q_q[WIDTH-1 -: CHUNK]),
        .gt_o (slice_gt),
        .lt_o (slice_lt),
        .eq_o (slice_eq)
    );

    // res_q remembers the first unequal slice; later slices cannot override it.
    always_comb begin
        slice_res = to_result(slice_gt, slice_lt);
        res_d     = (res_q != EQ || slice_eq) ? res_q : slice_res;
`ifdef COMP_CONST_LATENCY_EN
        last_d    = (idx_q == LAST_IDX);
`else
        last_d    = (idx_q == LAST_IDX) || !slice_eq;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            idx_q   <= '0;
            res_q   <= EQ;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Flipping both sign bits maps signed order onto unsigned order.
                        p_q     <= signed_mode ? (P ^ MSB_MASK) : P;
                        q_q     <= signed_mode ? (Q ^ MSB_MASK) : Q;
                        idx_q   <= '0;
                        res_q   <= EQ;
                        g_q     <= 1'b0;
                        l_q     <= 1'b0;
                        e_q     <= 1'b0;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    if (last_d) begin
                        g_q     <= (res_d == GT);
                        l_q     <= (res_d == LT);
                        e_q     <= (res_d == EQ);
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        p_q   <= p_q << CHUNK;
                        q_q   <= q_q << CHUNK;
                        idx_q <= idx_q + IDX_W'(1);
                        res_q <= res_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == CMP);
    assign done = done_q;
    assign G2   = g_q;
    assign L2   = l_q;
    assign E2   = e_q;

endmodule

// File: tb/tb_comp_nbit_seq.sv
// Self-checking bench for comp_nbit_seq: directed cases plus random compares
// against an arithmetic reference model.
module tb_comp_nbit_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NC    = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] P = '0;
    logic [WIDTH-1:0] Q = '0;
    logic             busy, done, G2, L2, E2;

    int checks   = 0;
    int failures = 0;

    comp_nbit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .P           (P),
        .Q           (Q),
        .busy        (busy),
        .done        (done),
        .G2          (G2),
        .L2          (L2),
        .E2          (E2)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // +1 greater, -1 less, 0 equal
    function automatic int ref_rel(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q,
                                   input bit sm);
        if (sm) return ($signed(p) > $signed(q)) ? 1 : (($signed(p) < $signed(q)) ? -1 : 0);
        return (p > q) ? 1 : ((p < q) ? -1 : 0);
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
`ifdef COMP_CONST_LATENCY_EN
        return NC;
`else
        int sh;
        for (int i = 0; i < NC; i++) begin
            sh = WIDTH - (i + 1) * CHUNK;
            if (((int'(p) >> sh) % (1 << CHUNK)) != ((int'(q) >> sh) % (1 << CHUNK)))
                return i + 1;
        end
        return NC;
`endif
    endfunction

    // Called away from an edge; returns #1 after the acceptance edge.
    task automatic issue(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q, input bit sm);
        P = p; Q = q; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        P = WIDTH'($urandom);
        Q = WIDTH'($urandom);
        signed_mode = 1'($urandom);
    endtask

    // Waits for done (bounded), counting edges already spent in cyc0.
    task automatic finish(input string tag, input int cyc0, input logic [WIDTH-1:0] p,
                          input logic [WIDTH-1:0] q, input bit sm);
        int cyc = cyc0;
        int rel = ref_rel(p, q, sm);
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < NC + 4);
        chkn({tag, "_latency"}, cyc, ref_lat(p, q));
        chk1({tag, "_done"}, done, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_G2"}, G2, rel > 0);
        chk1({tag, "_L2"}, L2, rel < 0);
        chk1({tag, "_E2"}, E2, rel == 0);
    endtask

    task automatic run_cmp(input string tag, input logic [WIDTH-1:0] p,
                           input logic [WIDTH-1:0] q, input bit sm);
        int rel = ref_rel(p, q, sm);
        @(negedge clk);
        issue(p, q, sm);
        chk1({tag, "_busy_on"}, busy, 1'b1);
        finish(tag, 0, p, q, sm);
        @(posedge clk); #1;
        chk1({tag, "_pulse_end"}, done, 1'b0);
        chk1({tag, "_hold"}, G2 && rel > 0 || L2 && rel < 0 || E2 && rel == 0, 1'b1);
    endtask

    initial begin
        logic [WIDTH-1:0] rp, rq;
        int cyc;
        #12;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_flags", G2 | L2 | E2, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        run_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0);
        run_cmp("uns_8000", 16'h8000, 16'h7FFF, 1'b0);
        run_cmp("sgn_8000", 16'h8000, 16'h7FFF, 1'b1);
        run_cmp("last_gt", 16'h1235, 16'h1234, 1'b0);
        run_cmp("last_lt", 16'h1234, 16'h1235, 1'b0);
        run_cmp("top_only", 16'h8000, 16'h0000, 1'b0);
        run_cmp("sgn_neg", 16'hFFFF, 16'hFFFE, 1'b1);

        // start while busy is ignored, then a back-to-back start in the done cycle
        @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0);
        @(posedge clk); #1;
        P = 16'hFFFF; Q = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish("ignored", 2, 16'h0001, 16'h0001, 1'b0);
        issue(16'h8000, 16'h7FFF, 1'b1);
        chk1("b2b_busy", busy, 1'b1);
        chk1("b2b_done_low", done, 1'b0);
        finish("b2b", 0, 16'h8000, 16'h7FFF, 1'b1);

        // reset in the middle of an equal compare
        @(negedge clk);
        issue(16'h1234, 16'h1234, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_flags", G2 | L2 | E2, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) cyc++;
        end
        chkn("abort_quiet", cyc, 0);

        for (int n = 0; n < 40; n++) begin
            rp = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rq = WIDTH'($urandom);
                1: rq = rp;
                2: rq = rp ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rq = rp ^ WIDTH'($urandom_range(0, 255));
            endcase
            run_cmp($sformatf("rnd%0d", n), rp, rq, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
